// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Shared definitions for the load/store controller:
//     - data width constant (only 32-bit words are supported)
//     - request size encodings (byte / half / word / illegal)
//     - controller state encodings and the state enum built on them
//     - access_error(): alignment / legality check applied at acceptance
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  localparam int DATA_W = 32;

  // Request size encodings carried on req_size
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Controller state encodings
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_LOAD_ENC   = 3'd1;
  localparam logic [2:0] ST_RMW_RD_ENC = 3'd2;
  localparam logic [2:0] ST_WRITE_ENC  = 3'd3;
  localparam logic [2:0] ST_RESP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_LOAD   = ST_LOAD_ENC,
    ST_RMW_RD = ST_RMW_RD_ENC,
    ST_WRITE  = ST_WRITE_ENC,
    ST_RESP   = ST_RESP_ENC
  } state_e;

  // Returns 1 when a request of this size at this byte offset cannot be
  // serviced: halves must be 2-byte aligned, words 4-byte aligned, and the
  // reserved size code is always rejected.
  function automatic logic access_error(input logic [1:0] size,
                                        input logic [1:0] offset);
    logic err;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = offset[0];
      SIZE_WORD: err = (offset != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational lane steering between a 32-bit RAM word and
//   right-justified CPU data. Lanes are little-endian: byte k lives in
//   bits [8k+7:8k]; a half lives in [15:0] (offset[1]=0) or [31:16].
//
// Ports
//   rd_word     in   32  word currently read from the RAM
//   offset      in    2  byte offset within the word (addr[1:0])
//   size        in    2  access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   is_unsigned in    1  zero-extend (1) or sign-extend (0) sub-word loads
//   wdata       in   32  right-justified store data
//   ld_data     out  32  extracted and extended load data
//   st_word     out  32  rd_word with the addressed lane(s) replaced by wdata
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rd_word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_word
);

  logic [4:0]        sh_byte;
  logic [4:0]        sh_half;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [DATA_W-1:0] byte_mask;
  logic [DATA_W-1:0] half_mask;

  always_comb begin
    // Bit position of the addressed lane; halves only use offset[1]
    sh_byte   = {offset, 3'b000};
    sh_half   = {offset[1], 4'b0000};
    byte_val  = 8'(rd_word >> sh_byte);
    half_val  = 16'(rd_word >> sh_half);
    byte_mask = 32'h0000_00FF << sh_byte;
    half_mask = 32'h0000_FFFF << sh_half;

    ld_data = '0;
    case (size)
      SIZE_BYTE: ld_data = is_unsigned ? {24'h0, byte_val}
                                       : {{24{byte_val[7]}}, byte_val};
      SIZE_HALF: ld_data = is_unsigned ? {16'h0, half_val}
                                       : {{16{half_val[15]}}, half_val};
      SIZE_WORD: ld_data = rd_word;
      default:   ld_data = '0;
    endcase

    st_word = rd_word;
    case (size)
      SIZE_BYTE: st_word = (rd_word & ~byte_mask) | ({24'h0, wdata[7:0]} << sh_byte);
      SIZE_HALF: st_word = (rd_word & ~half_mask) | ({16'h0, wdata[15:0]} << sh_half);
      SIZE_WORD: st_word = wdata;
      default:   st_word = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Initiator-side load/store controller between the CPU datapath and a
//   word-addressed RAM with a single write enable and combinational read.
//   Byte and half stores are done as read-modify-write; loads are extracted
//   and sign/zero extended; misaligned or illegal-size requests complete
//   with resp_err and never touch the RAM. One request in flight at a time.
//
// Handshake
//   A request transfers on a rising edge where req_valid && req_ready. The
//   requester holds every req_* field stable until that edge; req_valid
//   while req_ready is low is ignored. The response is a single-cycle
//   resp_valid pulse with no backpressure; resp_err and resp_rdata are only
//   meaningful while resp_valid is high.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    request handshake
//   req_we             1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       zero-extend sub-word loads when 1
//   req_addr           byte address
//   req_wdata          right-justified store data
//   resp_valid         one-cycle completion pulse
//   resp_err           misaligned / illegal size
//   resp_rdata         extended load data, 0 for stores and errors
//   mem_we             RAM write enable (exactly one cycle per store)
//   mem_addr           RAM byte address with the low two bits forced to 0
//   mem_wdata          RAM write word, 0 outside the write cycle
//   mem_rdata          RAM combinational read word
//
// Flow: IDLE -> LOAD -> RESP, IDLE -> WRITE -> RESP (word store),
//       IDLE -> RMW_RD -> WRITE -> RESP (sub-word store), IDLE -> RESP (error)
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int NUMBER_OF_ADDRESS_BITS = 10,
  parameter int NUMBER_OF_DATA_BITS    = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [1:0]                        req_size,
  input  logic                              req_unsigned,
  input  logic [NUMBER_OF_ADDRESS_BITS-1:0] req_addr,
  input  logic [NUMBER_OF_DATA_BITS-1:0]    req_wdata,
  output logic                              resp_valid,
  output logic                              resp_err,
  output logic [NUMBER_OF_DATA_BITS-1:0]    resp_rdata,
  output logic                              mem_we,
  output logic [NUMBER_OF_ADDRESS_BITS-1:0] mem_addr,
  output logic [NUMBER_OF_DATA_BITS-1:0]    mem_wdata,
  input  logic [NUMBER_OF_DATA_BITS-1:0]    mem_rdata
);

  localparam int N = NUMBER_OF_ADDRESS_BITS;

  // FSM state
  state_e state_q, state_d;

  // Request latched at acceptance
  logic [N-1:0]      addr_q,  addr_d;
  logic [1:0]        size_q,  size_d;
  logic              we_q,    we_d;
  logic              uns_q,   uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Registered outputs
  logic              mem_we_q,     mem_we_d;
  logic [N-1:0]      mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q,   resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  // Lane steering for the latched request against the live RAM read word
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;

  mem_lane_align u_lane_align (
    .rd_word     (mem_rdata),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  // rst_n is included so ready drops the moment reset is applied
  assign req_ready  = (state_q == ST_IDLE) && rst_n;

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that every output comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (access_error(req_size, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (req_size == SIZE_WORD) begin
            // Full-word store needs no read, write straight away
            state_d     = ST_WRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end

      ST_LOAD: begin
        // RAM read data is valid this cycle; capture the extended value
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? '0 : ld_data;
      end

      ST_RMW_RD: begin
        // Old word is on mem_rdata; capture it with the target lane merged
        state_d     = ST_WRITE;
        mem_we_d    = 1'b1;
        mem_wdata_d = st_word;
      end

      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Word address of the request being serviced, 0 whenever idle
    mem_addr_d = (state_d != ST_IDLE) ? {addr_d[N-1:2], 2'b00} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule
